// File: rtl/addr_cam_ctrl.sv
// Sequencer for the hot-page address CAM: search, count update, insert, reorder and migration.
// Optional feature: define HOT_CNT_DECAY_EN to halve all counts every DECAY_PERIOD accepted addresses.
module addr_cam_ctrl #(
  parameter int WORD_SIZE    = 28,
  parameter int CNT_SIZE     = 13,
  parameter int NUM_ENTRY    = 50,
  parameter int ENTRY_WIDTH  = 6,
  parameter int TOP_K        = 5,
  parameter int DECAY_PERIOD = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   addr_valid,
  input  logic [WORD_SIZE-1:0]   addr_in,
  output logic                   addr_ready,
  input  logic                   mig_req,
  input  logic [2:0]             mig_num,
  output logic                   mig_done,
  output logic                   cam_reset,
  output logic                   search_en,
  output logic [WORD_SIZE-1:0]   search_addr,
  input  logic                   match,
  input  logic [ENTRY_WIDTH-1:0] match_rank,
  output logic                   write_en,
  output logic [WORD_SIZE-1:0]   write_addr,
  output logic [ENTRY_WIDTH-1:0] write_rank,
  output logic                   sort_en,
  output logic [ENTRY_WIDTH-1:0] sort_hit_rank,
  output logic [ENTRY_WIDTH-1:0] sort_new_rank,
  output logic                   mig_en,
  output logic [2:0]             num_mig,
  output logic [ENTRY_WIDTH-1:0] minptr,
  output logic [CNT_SIZE-1:0]    top_cnt
);

  localparam logic [ENTRY_WIDTH-1:0] LP_FULL = ENTRY_WIDTH'(NUM_ENTRY);
  localparam logic [ENTRY_WIDTH-1:0] LP_LAST = ENTRY_WIDTH'(NUM_ENTRY - 1);
  localparam logic [2:0]             LP_TOPK = 3'(TOP_K);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEARCH, S_UPDATE, S_MIG} state_t;

  state_t                 r_state;
  logic                   r_addr_ready;
  logic                   r_cam_reset;
  logic                   r_search_en;
  logic                   r_write_en;
  logic                   r_sort_en;
  logic                   r_mig_en;
  logic                   r_mig_done;
  logic                   r_pending;
  logic [2:0]             r_mig_num;
  logic [2:0]             r_num_mig;
  logic [ENTRY_WIDTH-1:0] r_minptr;
  logic [ENTRY_WIDTH-1:0] r_rank;
  logic [ENTRY_WIDTH-1:0] r_new_rank;
  logic [ENTRY_WIDTH-1:0] r_write_rank;
  logic [WORD_SIZE-1:0]   r_addr;
  logic                   r_match;
  logic [CNT_SIZE-1:0]    r_cnt     [NUM_ENTRY];

  logic [CNT_SIZE-1:0]    w_cnt_nxt [NUM_ENTRY];
  logic [CNT_SIZE-1:0]    w_hit_c;
  logic                   w_hit_sat;
  logic [ENTRY_WIDTH-1:0] w_new_rank;
  logic                   w_pend_set;
  logic                   w_pend_nxt;
  logic [2:0]             w_mig_clamp;
  logic                   w_accept;
  logic                   w_decay;

  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && !r_pending && addr_valid && r_addr_ready;
  assign w_mig_clamp = (mig_num > LP_TOPK) ? LP_TOPK : mig_num;
  assign w_pend_set  = mig_req && !r_pending;
  assign w_pend_nxt  = (r_state == S_MIG) ? 1'b0 : (r_pending || mig_req);

  // The hit entry jumps ahead of every tie: the lowest rank holding the same count.
  always_comb begin
    w_hit_c    = r_cnt[match_rank];
    w_hit_sat  = &w_hit_c;
    w_new_rank = match_rank;
    for (int j = NUM_ENTRY - 1; j >= 0; j--) begin
      if ((ENTRY_WIDTH'(j) <= match_rank) && (r_cnt[j] == w_hit_c))
        w_new_rank = ENTRY_WIDTH'(j);
    end
  end

`ifdef HOT_CNT_DECAY_EN
  localparam int DEC_W = $clog2(DECAY_PERIOD) + 1;

  logic [DEC_W-1:0] r_dec_cnt;
  logic             r_dec_fire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dec_cnt  <= '0;
      r_dec_fire <= 1'b0;
    end else if (w_accept) begin
      if (r_dec_cnt == DEC_W'(DECAY_PERIOD - 1)) begin
        r_dec_cnt  <= '0;
        r_dec_fire <= 1'b1;
      end else begin
        r_dec_cnt  <= r_dec_cnt + 1'b1;
        r_dec_fire <= 1'b0;
      end
    end else if (r_state == S_UPDATE) begin
      r_dec_fire <= 1'b0;
    end
  end

  assign w_decay = r_dec_fire && (r_state == S_UPDATE);
`else
  assign w_decay = 1'b0;
`endif

  // Ranks n..r-1 already hold the hit count, so the rank shift only changes cnt[n].
  always_comb begin
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_INIT: begin
        for (int j = 0; j < NUM_ENTRY; j++) w_cnt_nxt[j] = '0;
      end
      S_UPDATE: begin
        if (r_match) w_cnt_nxt[r_new_rank] = sat_inc(r_cnt[r_rank]);
        else         w_cnt_nxt[r_write_rank] = CNT_SIZE'(1);
        if (w_decay) begin
          for (int j = 0; j < NUM_ENTRY; j++) w_cnt_nxt[j] = w_cnt_nxt[j] >> 1;
        end
      end
      S_MIG: begin
        for (int j = 0; j < NUM_ENTRY; j++) w_cnt_nxt[j] = '0;
        for (int k = 0; k <= TOP_K; k++) begin
          if (r_num_mig == 3'(k)) begin
            for (int j = 0; j < NUM_ENTRY - k; j++) w_cnt_nxt[j] = r_cnt[j + k];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_INIT;
      r_cam_reset  <= 1'b1;
      r_addr_ready <= 1'b0;
      r_search_en  <= 1'b0;
      r_write_en   <= 1'b0;
      r_sort_en    <= 1'b0;
      r_mig_en     <= 1'b0;
      r_mig_done   <= 1'b0;
      r_pending    <= 1'b0;
      r_mig_num    <= '0;
      r_num_mig    <= '0;
      r_minptr     <= '0;
      r_rank       <= '0;
      r_new_rank   <= '0;
      r_write_rank <= '0;
      r_addr       <= '0;
      r_match      <= 1'b0;
      for (int j = 0; j < NUM_ENTRY; j++) r_cnt[j] <= '0;
    end else begin
      r_pending   <= w_pend_nxt;
      if (w_pend_set) r_mig_num <= w_mig_clamp;
      r_cnt       <= w_cnt_nxt;
      r_cam_reset <= 1'b0;
      r_search_en <= 1'b0;
      r_write_en  <= 1'b0;
      r_sort_en   <= 1'b0;
      r_mig_en    <= 1'b0;
      r_mig_done  <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_minptr     <= '0;
          r_state      <= S_IDLE;
          r_addr_ready <= !w_pend_nxt;
        end
        S_IDLE: begin
          if (r_pending) begin
            r_state      <= S_MIG;
            r_addr_ready <= 1'b0;
            r_mig_en     <= 1'b1;
            r_mig_done   <= 1'b1;
            r_num_mig    <= r_mig_num;
          end else if (w_accept) begin
            r_state      <= S_SEARCH;
            r_addr       <= addr_in;
            r_addr_ready <= 1'b0;
            r_search_en  <= 1'b1;
          end else begin
            r_addr_ready <= !w_pend_nxt;
          end
        end
        // search -> update: capture the CAM result and prepare the update command
        S_SEARCH: begin
          r_state <= S_UPDATE;
          r_match <= match;
          r_rank  <= match_rank;
          if (match) begin
            r_new_rank <= w_new_rank;
            r_sort_en  <= !w_hit_sat && (w_new_rank != match_rank);
          end else begin
            r_write_en   <= 1'b1;
            r_write_rank <= (r_minptr < LP_FULL) ? r_minptr : LP_LAST;
          end
        end
        // update -> idle: counts commit together with the CAM operation
        S_UPDATE: begin
          if (!r_match && (r_minptr < LP_FULL)) r_minptr <= r_minptr + 1'b1;
          r_state      <= S_IDLE;
          r_addr_ready <= !w_pend_nxt;
        end
        S_MIG: begin
          r_minptr     <= (r_minptr > ENTRY_WIDTH'(r_num_mig)) ?
                          r_minptr - ENTRY_WIDTH'(r_num_mig) : '0;
          r_state      <= S_IDLE;
          r_addr_ready <= !w_pend_nxt;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

  // CAM commands are suppressed while reset is asserted so an aborted update never reaches it.
  assign addr_ready    = r_addr_ready;
  assign mig_done      = r_mig_done;
  assign cam_reset     = r_cam_reset;
  assign search_en     = r_search_en & reset_n;
  assign search_addr   = r_addr;
  assign write_en      = r_write_en & reset_n;
  assign write_addr    = r_addr;
  assign write_rank    = r_write_rank;
  assign sort_en       = r_sort_en & reset_n;
  assign sort_hit_rank = r_rank;
  assign sort_new_rank = r_new_rank;
  assign mig_en        = r_mig_en & reset_n;
  assign num_mig       = r_num_mig;
  assign minptr        = r_minptr;
  assign top_cnt       = r_cnt[0];

endmodule

// File: tb/tb_addr_cam_ctrl.sv
// Randomized bench for addr_cam_ctrl; plays the CAM from a queue-based ranked-list reference model.
module tb_addr_cam_ctrl;
  localparam int WS   = 28;
  localparam int CS   = 13;
  localparam int NE   = 50;
  localparam int EW   = 6;
  localparam int TK   = 5;
  localparam int DP   = 4;
  localparam int CMAX = (1 << CS) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          addr_valid = 1'b0;
  logic [WS-1:0] addr_in = '0;
  logic          addr_ready;
  logic          mig_req = 1'b0;
  logic [2:0]    mig_num = '0;
  logic          mig_done;
  logic          cam_reset;
  logic          search_en;
  logic [WS-1:0] search_addr;
  logic          match = 1'b0;
  logic [EW-1:0] match_rank = '0;
  logic          write_en;
  logic [WS-1:0] write_addr;
  logic [EW-1:0] write_rank;
  logic          sort_en;
  logic [EW-1:0] sort_hit_rank;
  logic [EW-1:0] sort_new_rank;
  logic          mig_en;
  logic [2:0]    num_mig;
  logic [EW-1:0] minptr;
  logic [CS-1:0] top_cnt;

  addr_cam_ctrl #(
    .WORD_SIZE(WS), .CNT_SIZE(CS), .NUM_ENTRY(NE), .ENTRY_WIDTH(EW),
    .TOP_K(TK), .DECAY_PERIOD(DP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr_valid(addr_valid), .addr_in(addr_in),
    .addr_ready(addr_ready), .mig_req(mig_req), .mig_num(mig_num), .mig_done(mig_done),
    .cam_reset(cam_reset), .search_en(search_en), .search_addr(search_addr),
    .match(match), .match_rank(match_rank), .write_en(write_en), .write_addr(write_addr),
    .write_rank(write_rank), .sort_en(sort_en), .sort_hit_rank(sort_hit_rank),
    .sort_new_rank(sort_new_rank), .mig_en(mig_en), .num_mig(num_mig), .minptr(minptr),
    .top_cnt(top_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: valid entries in rank order with their counts.
  logic [WS-1:0] q_addr[$];
  int            q_cnt[$];
  int            acc_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_find(input logic [WS-1:0] a);
    for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic int first_eq(input int c);
    for (int i = 0; i < q_cnt.size(); i++) if (q_cnt[i] == c) return i;
    return -1;
  endfunction

  task automatic ref_reset();
    q_addr.delete();
    q_cnt.delete();
    acc_total = 0;
  endtask

  task automatic ref_decay();
`ifdef HOT_CNT_DECAY_EN
    if (acc_total % DP == 0) foreach (q_cnt[i]) q_cnt[i] = q_cnt[i] / 2;
`endif
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_minptr"}, 32'(minptr), 32'(q_addr.size()));
    check_eq({tag, "_top_cnt"}, 32'(top_cnt), (q_cnt.size() > 0) ? 32'(q_cnt[0]) : 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; addr_valid = 1'b0; mig_req = 1'b0; match = 1'b0; match_rank = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_addr_ready", 32'(addr_ready), 0);
    check_eq("rst_cam_reset", 32'(cam_reset), 1);
    check_eq("rst_mig_done", 32'(mig_done), 0);
    check_eq("rst_enables", 32'({search_en, write_en, sort_en, mig_en}), 0);
    check_eq("rst_addrs", 32'(search_addr | write_addr), 0);
    check_eq("rst_ranks", 32'({write_rank, sort_hit_rank, sort_new_rank, num_mig}), 0);
    check_eq("rst_minptr", 32'(minptr), 0);
    check_eq("rst_top_cnt", 32'(top_cnt), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("init_cam_reset_off", 32'(cam_reset), 0);
    check_eq("init_ready", 32'(addr_ready), 1);
    ref_reset();
  endtask

  task automatic mig_cycle(input logic [2:0] k);
    int kk;
    kk = (int'(k) > TK) ? TK : int'(k);
    check_eq("mig_en", 32'(mig_en), 1);
    check_eq("mig_done", 32'(mig_done), 1);
    check_eq("mig_num_out", 32'(num_mig), 32'(kk));
    check_eq("mig_minptr_old", 32'(minptr), 32'(q_addr.size()));
    check_eq("mig_others_off", 32'({search_en, write_en, sort_en}), 0);
    repeat (kk) begin
      if (q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_cnt.pop_front());
      end
    end
    @(negedge clk);
    check_eq("mig_en_off", 32'(mig_en), 0);
    check_eq("mig_done_off", 32'(mig_done), 0);
    check_eq("mig_ready", 32'(addr_ready), 1);
    check_idle("post_mig");
  endtask

  task automatic do_mig(input logic [2:0] k);
    mig_req = 1'b1; mig_num = k;
    @(negedge clk);
    mig_req = 1'b0; mig_num = '0;
    check_eq("mig_pend_ready", 32'(addr_ready), 0);
    check_eq("mig_pend_en", 32'(mig_en), 0);
    @(negedge clk);
    mig_cycle(k);
  endtask

  task automatic access(input logic [WS-1:0] a, input bit with_mig, input logic [2:0] k);
    int guard, r, n, c, wr;
    guard = 0;
    while (addr_ready !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    check_eq("acc_ready", 32'(addr_ready), 1);
    if (addr_ready !== 1'b1) return;
    addr_valid = 1'b1; addr_in = a;
    @(negedge clk);
    addr_valid = 1'b0;
    check_eq("search_en", 32'(search_en), 1);
    check_eq("search_addr", 32'(search_addr), 32'(a));
    r = ref_find(a);
    match = (r >= 0);
    match_rank = (r >= 0) ? EW'(r) : '0;
    if (with_mig) begin mig_req = 1'b1; mig_num = k; end
    @(negedge clk);
    match = 1'b0; match_rank = '0; mig_req = 1'b0; mig_num = '0;
    check_eq("search_off", 32'(search_en), 0);
    acc_total++;
    if (r >= 0) begin
      c = q_cnt[r];
      check_eq("hit_write_off", 32'(write_en), 0);
      if (c == CMAX) begin
        check_eq("sat_sort_off", 32'(sort_en), 0);
      end else begin
        n = first_eq(c);
        check_eq("sort_en", 32'(sort_en), (n != r) ? 32'd1 : 32'd0);
        if (n != r) begin
          check_eq("sort_hit_rank", 32'(sort_hit_rank), 32'(r));
          check_eq("sort_new_rank", 32'(sort_new_rank), 32'(n));
        end
        q_addr.delete(r); q_cnt.delete(r);
        q_addr.insert(n, a); q_cnt.insert(n, c + 1);
      end
    end else begin
      wr = (q_addr.size() < NE) ? q_addr.size() : NE - 1;
      check_eq("miss_sort_off", 32'(sort_en), 0);
      check_eq("write_en", 32'(write_en), 1);
      check_eq("write_addr", 32'(write_addr), 32'(a));
      check_eq("write_rank", 32'(write_rank), 32'(wr));
      if (q_addr.size() < NE) begin
        q_addr.push_back(a); q_cnt.push_back(1);
      end else begin
        q_addr[NE-1] = a; q_cnt[NE-1] = 1;
      end
    end
    ref_decay();
    @(negedge clk);
    check_eq("idle_cmds_off", 32'({write_en, sort_en, search_en}), 0);
    check_idle("idle");
    if (with_mig) begin
      check_eq("pend_blocks_ready", 32'(addr_ready), 0);
      @(negedge clk);
      mig_cycle(k);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [WS-1:0] a;
    int sel, exp_top;
    apply_reset();

    // First insert, then tie-breaking on hits.
    access(28'h100, 1'b0, 3'd0);
    access(28'h200, 1'b0, 3'd0);
    access(28'h300, 1'b0, 3'd0);
    access(28'h300, 1'b0, 3'd0);
    access(28'h300, 1'b0, 3'd0);

    // Fill, then replace the coldest entry and hit it.
    apply_reset();
    for (int i = 0; i < NE; i++) access(WS'(32'h1000 + i), 1'b0, 3'd0);
    access(28'hDDD0, 1'b0, 3'd0);
    access(28'hDDD0, 1'b0, 3'd0);

    // Migration raised during SEARCH, then clamped/no-op/over-drain migrations.
    apply_reset();
    for (int i = 0; i < 7; i++) access(WS'(32'h2000 + i), 1'b0, 3'd0);
    access(WS'(32'h2003), 1'b1, 3'd3);
    do_mig(3'd0);
    do_mig(3'd7);
    do_mig(3'd5);

    // Reset asserted during UPDATE of a miss.
    access(28'h4000, 1'b0, 3'd0);
    addr_valid = 1'b1; addr_in = 28'h4010;
    @(negedge clk);
    addr_valid = 1'b0; match = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("rst_upd_write_off", 32'(write_en), 0);
    @(negedge clk);
    check_eq("rst_upd_cam_reset", 32'(cam_reset), 1);
    check_eq("rst_upd_minptr", 32'(minptr), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_upd_ready", 32'(addr_ready), 1);
    check_eq("rst_upd_cam_off", 32'(cam_reset), 0);
    ref_reset();

    // Four accesses of one address.
    repeat (4) access(28'h5000, 1'b0, 3'd0);
`ifdef HOT_CNT_DECAY_EN
    exp_top = 2;
`else
    exp_top = 4;
`endif
    check_eq("four_hits_top", 32'(top_cnt), 32'(exp_top));

    // Random traffic over a pool larger than the CAM.
    apply_reset();
    for (int it = 0; it < 500; it++) begin
      sel = int'($urandom_range(0, 99));
      a = WS'(32'h100 + 16 * $urandom_range(0, 63));
      if (sel < 80)      access(a, 1'b0, 3'd0);
      else if (sel < 90) access(a, 1'b1, 3'($urandom_range(0, 7)));
      else               do_mig(3'($urandom_range(0, 7)));
    end

    // Saturation of the hottest counter.
    apply_reset();
    for (int i = 0; i < CMAX + 2; i++) access(28'h7770, 1'b0, 3'd0);
    access(28'h7780, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
